// File: rtl/buff_pkg.sv
// Shared defaults and FSM state types for the buff_ctrl ping-pong frame controller.
package buff_pkg;

    localparam int unsigned DEF_DATA_BITS = 16;
    localparam int unsigned DEF_ADDR_BITS = 10;
    localparam int unsigned DEF_FRAME_LEN = 1024;

    typedef enum logic [1:0] {
        W_FILL,
        W_WAIT,
        W_SWAP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_STREAM,
        R_DRAIN
    } rd_state_e;

endpackage

// File: rtl/buff_ctrl_skid.sv
// Small FIFO catching buffer read data; valid/ready on the output, free-slot count for read credit.
module buff_ctrl_skid #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               push_data_i,
    output logic [WIDTH-1:0]               pop_data_o,
    output logic                           pop_vld_o,
    input  logic                           pop_ready_i,
    output logic [$clog2(DEPTH + 1)-1:0]   free_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_vld_o  = (cnt_q != '0);
    assign pop        = pop_vld_o && pop_ready_i;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign free_o     = CW'(DEPTH) - cnt_q;

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push_i) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/buff_ctrl.sv
// Ping-pong frame controller: fills the write bank, swaps when the reader is idle, streams the read bank.
// Define BUFF_CTRL_OVR_EN to enable the sticky overrun flag and saturating drop counter.
module buff_ctrl
    import buff_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
    parameter int unsigned FRAME_LEN  = DEF_FRAME_LEN,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                 clk2,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] sample_i,
    input  logic                 sample_vld_i,
    output logic                 buff_sel_o,
    output logic [ADDR_BITS-1:0] buff_waddr_o,
    output logic [DATA_BITS-1:0] buff_wdata_o,
    output logic [ADDR_BITS-1:0] buff_raddr_o,
    input  logic [DATA_BITS-1:0] buff_rdata_i,
    output logic [DATA_BITS-1:0] rd_data_o,
    output logic                 rd_vld_o,
    output logic                 rd_last_o,
    input  logic                 rd_ready_i,
    output logic                 ovr_o,
    output logic [15:0]          ovr_cnt_o
);

    localparam int unsigned DEPTH = RD_LATENCY + 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FRAME_LEN - 1);

    wr_state_e w_state_q, w_state_d;
    rd_state_e r_state_q, r_state_d;

    logic [ADDR_BITS-1:0]  wptr_q, wptr_d, waddr_q, waddr_d, rptr_q, rptr_d;
    logic [DATA_BITS-1:0]  wdata_q, wdata_d;
    logic                  sel_q, sel_d;
    logic [RD_LATENCY-1:0] pend_q, pend_d, pend_last_q, pend_last_d;
    logic                  issue, pop;
    logic [CW-1:0]         free;
    logic [DATA_BITS:0]    head;
    logic                  head_vld;
    int unsigned           inflight;

    always_comb begin
        w_state_d = w_state_q;
        wptr_d    = wptr_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        sel_d     = sel_q;
        case (w_state_q)
            W_FILL: begin
                if (sample_vld_i) begin
                    waddr_d = wptr_q;
                    wdata_d = sample_i;
                    if (wptr_q == LAST_ADDR) begin
                        wptr_d    = '0;
                        w_state_d = (r_state_q == R_IDLE) ? W_SWAP : W_WAIT;
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                end
            end
            W_WAIT: if (r_state_q == R_IDLE) w_state_d = W_SWAP;
            W_SWAP: begin
                sel_d     = ~sel_q;
                wptr_d    = '0;
                w_state_d = W_FILL;
            end
            default: w_state_d = W_FILL;
        endcase
    end

    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) inflight += 32'(pend_q[i]);
        issue     = 1'b0;
        r_state_d = r_state_q;
        rptr_d    = rptr_q;
        case (r_state_q)
            R_IDLE: begin
                if (w_state_q == W_SWAP) begin
                    r_state_d = R_STREAM;
                    rptr_d    = '0;
                end
            end
            R_STREAM: begin
                // a word leaving the skid this cycle frees the slot for the read issued now
                issue = (32'(free) + 32'(pop)) > inflight;
                if (issue) begin
                    if (rptr_q == LAST_ADDR) begin
                        rptr_d    = '0;
                        r_state_d = R_DRAIN;
                    end else begin
                        rptr_d = rptr_q + 1'b1;
                    end
                end
            end
            R_DRAIN: if (pop && head[DATA_BITS]) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
        pend_d      = (pend_q << 1) | RD_LATENCY'(issue);
        pend_last_d = (pend_last_q << 1) | RD_LATENCY'(issue && (rptr_q == LAST_ADDR));
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            w_state_q   <= W_FILL;
            r_state_q   <= R_IDLE;
            wptr_q      <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            rptr_q      <= '0;
            sel_q       <= 1'b0;
            pend_q      <= '0;
            pend_last_q <= '0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            wptr_q      <= wptr_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            rptr_q      <= rptr_d;
            sel_q       <= sel_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
        end
    end

    buff_ctrl_skid #(
        .WIDTH (DATA_BITS + 1),
        .DEPTH (DEPTH)
    ) u_skid (
        .clk_i       (clk2),
        .rst_i       (rst),
        .push_i      (pend_q[RD_LATENCY-1]),
        .push_data_i ({pend_last_q[RD_LATENCY-1], buff_rdata_i}),
        .pop_data_o  (head),
        .pop_vld_o   (head_vld),
        .pop_ready_i (rd_ready_i),
        .free_o      (free)
    );

    assign pop          = head_vld && rd_ready_i;
    assign rd_vld_o     = head_vld;
    assign rd_data_o    = head[DATA_BITS-1:0];
    assign rd_last_o    = head_vld && head[DATA_BITS];
    assign buff_sel_o   = sel_q;
    assign buff_waddr_o = waddr_q;
    assign buff_wdata_o = wdata_q;
    assign buff_raddr_o = rptr_q;

`ifdef BUFF_CTRL_OVR_EN
    logic        drop;
    logic        ovr_q;
    logic [15:0] ovr_cnt_q;

    assign drop = (w_state_q == W_WAIT) && sample_vld_i;

    always_ff @(posedge clk2) begin
        if (rst) begin
            ovr_q     <= 1'b0;
            ovr_cnt_q <= '0;
        end else if (drop) begin
            ovr_q <= 1'b1;
            if (ovr_cnt_q != '1) ovr_cnt_q <= ovr_cnt_q + 1'b1;
        end
    end

    assign ovr_o     = ovr_q;
    assign ovr_cnt_o = ovr_cnt_q;
`else
    assign ovr_o     = 1'b0;
    assign ovr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_buff_ctrl.sv
// Bench for buff_ctrl: default instance (1024 words, latency 1) plus a 16-word, latency-2 instance,
// each attached to a behavioural double-buffer RAM; streamed words are scored against a frame queue model.
module tb_buff_ctrl;

    localparam int unsigned FL  = 1024;
    localparam int unsigned SFL = 16;

    logic clk2 = 1'b0;
    always #10 clk2 = ~clk2;

    logic        rst;
    logic [15:0] sample, wdata, rdata_buf, rd_data, ovr_cnt;
    logic [9:0]  waddr, raddr;
    logic        sample_vld, sel, rd_vld, rd_last, rd_ready, ovr;

    logic [15:0] s_sample, s_wdata, s_rdata_buf, s_rd_data, s_ovr_cnt, s_r1;
    logic [9:0]  s_waddr, s_raddr;
    logic        s_vld_in, s_sel, s_rd_vld, s_rd_last, s_rd_ready, s_ovr;

    buff_ctrl u_dut (
        .clk2(clk2), .rst(rst), .sample_i(sample), .sample_vld_i(sample_vld),
        .buff_sel_o(sel), .buff_waddr_o(waddr), .buff_wdata_o(wdata),
        .buff_raddr_o(raddr), .buff_rdata_i(rdata_buf),
        .rd_data_o(rd_data), .rd_vld_o(rd_vld), .rd_last_o(rd_last), .rd_ready_i(rd_ready),
        .ovr_o(ovr), .ovr_cnt_o(ovr_cnt)
    );

    buff_ctrl #(.FRAME_LEN(SFL), .RD_LATENCY(2)) u_small (
        .clk2(clk2), .rst(rst), .sample_i(s_sample), .sample_vld_i(s_vld_in),
        .buff_sel_o(s_sel), .buff_waddr_o(s_waddr), .buff_wdata_o(s_wdata),
        .buff_raddr_o(s_raddr), .buff_rdata_i(s_rdata_buf),
        .rd_data_o(s_rd_data), .rd_vld_o(s_rd_vld), .rd_last_o(s_rd_last), .rd_ready_i(s_rd_ready),
        .ovr_o(s_ovr), .ovr_cnt_o(s_ovr_cnt)
    );

    // Double buffer: sel=1 writes bank A and reads bank B, sel=0 the opposite.
    logic [15:0] bank_a [1024], bank_b [1024], sbank_a [1024], sbank_b [1024];
    always @(posedge clk2) begin
        if (sel) bank_a[waddr] <= wdata; else bank_b[waddr] <= wdata;
        rdata_buf <= sel ? bank_b[raddr] : bank_a[raddr];
        if (s_sel) sbank_a[s_waddr] <= s_wdata; else sbank_b[s_waddr] <= s_wdata;
        s_r1        <= s_sel ? sbank_b[s_raddr] : sbank_a[s_raddr];
        s_rdata_buf <= s_r1;
    end

    int unsigned n_chk = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame-level model: samples collect into fill_q; a full frame goes straight to the
    // stream queue when nothing is outstanding, else it is held and later strobes are dropped.
    logic [15:0] exp_q[$], fill_q[$], held_q[$];
    int unsigned drops = 0, acc_cnt = 0, frame_pos = 0, ready_mode = 1;
    logic        m_sel = 1'b0;
    logic        stall_prev = 1'b0;
    logic [15:0] stall_data = '0;

    initial forever begin
        @(posedge clk2); #1;
        rd_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(ready_mode);
    end

    initial forever begin
        @(negedge clk2);
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_vld", 32'(rd_vld), 1);
                chk("hold_data", 32'(rd_data), 32'(stall_data));
            end
            if (rd_vld && rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 32'(rd_vld), 0);
                end else begin
                    chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
                    chk("rd_last", 32'(rd_last), 32'(frame_pos == FL - 1));
                    frame_pos = (frame_pos == FL - 1) ? 0 : frame_pos + 1;
                    acc_cnt++;
                    if (exp_q.size() == 0 && held_q.size() != 0) begin
                        exp_q = held_q;
                        held_q.delete();
                        m_sel = ~m_sel;
                    end
                end
            end
            stall_prev = rd_vld && !rd_ready;
            stall_data = rd_data;
        end
    end

    task automatic send(input logic [15:0] v);
        int unsigned idx;
        bit accepted, swap_now;
        logic old_sel;
        idx      = fill_q.size();
        accepted = (held_q.size() == 0);
        swap_now = 1'b0;
        old_sel  = m_sel;
        @(negedge clk2);
        sample = v;
        sample_vld = 1'b1;
        if (accepted) begin
            fill_q.push_back(v);
            if (fill_q.size() == FL) begin
                if (exp_q.size() == 0) begin
                    exp_q = fill_q;
                    swap_now = 1'b1;
                    m_sel = ~m_sel;
                end else begin
                    held_q = fill_q;
                end
                fill_q.delete();
            end
        end else begin
            drops++;
        end
        @(negedge clk2);
        sample_vld = 1'b0;
        if (accepted) begin
            chk("waddr", 32'(waddr), idx);
            chk("wdata", 32'(wdata), 32'(v));
        end
        if (swap_now) chk("sel_before_swap", 32'(sel), 32'(old_sel));
        @(negedge clk2);
        if (swap_now) chk("sel_swap", 32'(sel), 32'(m_sel));
        repeat ($urandom_range(0, 2)) @(negedge clk2);
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || held_q.size() != 0) && n < 20000) begin
            @(negedge clk2);
            n++;
        end
        chk("drain", exp_q.size() + held_q.size(), 0);
        repeat (5) @(negedge clk2);
    endtask

    task automatic check_ovr();
`ifdef BUFF_CTRL_OVR_EN
        chk("ovr", 32'(ovr), 32'(drops > 0));
        chk("ovr_cnt", 32'(ovr_cnt), (drops > 16'hFFFF) ? 16'hFFFF : drops);
`else
        chk("ovr", 32'(ovr), 0);
        chk("ovr_cnt", 32'(ovr_cnt), 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        logic [15:0] svals [SFL];
        int unsigned base, n;

        rst = 1'b1; sample = '0; sample_vld = 1'b0; rd_ready = 1'b1;
        s_sample = '0; s_vld_in = 1'b0; s_rd_ready = 1'b1;

        // reset values
        repeat (2) @(negedge clk2);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_waddr", 32'(waddr), 0);
        chk("rst_wdata", 32'(wdata), 0);
        chk("rst_raddr", 32'(raddr), 0);
        chk("rst_vld", 32'(rd_vld), 0);
        chk("rst_last", 32'(rd_last), 0);
        chk("rst_ovr", 32'(ovr), 0);
        chk("rst_ovr_cnt", 32'(ovr_cnt), 0);
        chk("rst_s_sel", 32'(s_sel), 0);
        chk("rst_s_vld", 32'(s_rd_vld), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk2);
        chk("idle_vld", 32'(rd_vld), 0);

        // 16-word frame, read latency 2: swap after 16 strobes, back-to-back stream
        for (int i = 0; i < SFL; i++) begin
            svals[i] = 16'($urandom);
            s_sample = svals[i];
            s_vld_in = 1'b1;
            @(negedge clk2);
            s_vld_in = 1'b0;
            chk("s_waddr", 32'(s_waddr), i);
            chk("s_wdata", 32'(s_wdata), 32'(svals[i]));
            if (i == SFL - 1) chk("s_sel_before", 32'(s_sel), 0);
            @(negedge clk2);
            if (i == SFL - 1) chk("s_sel_swap", 32'(s_sel), 1);
            else @(negedge clk2);
        end
        @(negedge clk2);
        chk("s_vld_lat1", 32'(s_rd_vld), 0);
        @(negedge clk2);
        chk("s_vld_lat2", 32'(s_rd_vld), 0);
        for (int i = 0; i < SFL; i++) begin
            @(negedge clk2);
            chk("s_vld", 32'(s_rd_vld), 1);
            chk("s_data", 32'(s_rd_data), 32'(svals[i]));
            chk("s_last", 32'(s_rd_last), 32'(i == SFL - 1));
        end
        @(negedge clk2);
        chk("s_vld_end", 32'(s_rd_vld), 0);

        // full frame, sample = index, ready held high
        ready_mode = 1;
        base = acc_cnt;
        for (int i = 0; i < FL; i++) send(16'(i));
        wait_drain();
        chk("full_count", acc_cnt - base, FL);

        // random backpressure, random data
        ready_mode = 2;
        base = acc_cnt;
        for (int i = 0; i < FL; i++) send(16'($urandom));
        wait_drain();
        chk("bp_count", acc_cnt - base, FL);
        repeat (10) @(negedge clk2);
        chk("bp_idle_vld", 32'(rd_vld), 0);

        // overrun: reader stalled, second frame fills, five more strobes dropped
        ready_mode = 0;
        for (int i = 0; i < FL; i++) send(16'($urandom));
        for (int i = 0; i < FL; i++) send(16'($urandom));
        for (int i = 0; i < 5; i++) send(16'($urandom));
        chk("ovr_sel_held", 32'(sel), 32'(m_sel));
        chk("ovr_stall_vld", 32'(rd_vld), 1);
        check_ovr();
        ready_mode = 1;
        wait_drain();
        chk("ovr_sel_after", 32'(sel), 32'(m_sel));
        check_ovr();

        // reset in the middle of a stream
        ready_mode = 2;
        for (int i = 0; i < FL; i++) send(16'($urandom));
        base = acc_cnt;
        n = 0;
        while (acc_cnt - base < 300 && n < 10000) begin
            @(posedge clk2); #2;
            n++;
        end
        chk("words_before_rst", acc_cnt - base, 300);
        rst = 1'b1;
        exp_q.delete(); held_q.delete(); fill_q.delete();
        frame_pos = 0; m_sel = 1'b0; drops = 0;
        @(posedge clk2);
        @(negedge clk2);
        chk("midrst_vld", 32'(rd_vld), 0);
        chk("midrst_sel", 32'(sel), 0);
        chk("midrst_ovr", 32'(ovr), 0);
        rst = 1'b0;
        base = acc_cnt;
        for (int i = 0; i < FL; i++) send(16'($urandom));
        wait_drain();
        chk("fresh_count", acc_cnt - base, FL);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
